// File: rtl/lsu.sv
// lsu - load/store unit between the rv32i execute stage and the shared memory bus.
//
// Each request is serviced as one word read followed by one word write-back.
// The write-back happens even for loads, where the word goes back unchanged.
// Byte and halfword stores merge their data into the word that was read.
// The memory latches its write on the 1->0 edge of o_memread. Whenever
// o_memread is 0, the unit drives b_membus with wdata_q, so every such edge
// commits well-defined data.
//
// Ports:
//   i_clk      clock, all state changes on the rising edge
//   i_nreset   synchronous active-low reset
//   i_req      request strobe, sampled only in IDLE
//   i_we       1 = store, 0 = load
//   i_funct3   000 B, 001 H, 010 W, 100 BU, 101 HU
//   i_addr     byte address
//   i_wdata    store data (low byte/half used for SB/SH)
//   o_busy     high in every non-IDLE state
//   o_done     one-cycle completion pulse
//   o_fault    with o_done: misaligned access or illegal funct3
//   o_rdata    extended load result, held until the next o_done
//   o_memaddr  registered word address
//   o_memread  1 = memory drives b_membus; falling edge = write strobe
//   b_membus   shared data bus, driven by lsu while o_memread = 0
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for i_req; bus driven with wdata_q
// RD    | memory drives the word; capture it and build the commit value
// MRG   | commit value held stable in wdata_q for one full cycle
// CMT   | o_memread falls (write strobe), o_done, o_rdata valid
// FLT   | illegal request: o_done + o_fault, no bus activity
module lsu (
    input  logic        i_clk,
    input  logic        i_nreset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_fault,
    output logic [31:0] o_rdata,
    output logic [31:0] o_memaddr,
    output logic        o_memread,
    inout  wire  [31:0] b_membus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_MRG  = 3'd2,
        S_CMT  = 3'd3,
        S_FLT  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  boff_q;
    logic [31:0] wdin_q;
    logic [31:0] word_q;
    logic [31:0] wdata_q;
    logic        illegal;
    logic [31:0] merged;
    logic [31:0] extracted;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    assign b_membus = o_memread ? 32'bz : wdata_q;

    always_comb begin
        illegal = 1'b0;
        case (i_funct3)
            3'b000:  illegal = 1'b0;
            3'b001:  illegal = i_addr[0];
            3'b010:  illegal = |i_addr[1:0];
            3'b100:  illegal = i_we;
            3'b101:  illegal = i_we | i_addr[0];
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_nx  = state;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        o_fault   = 1'b0;
        o_memread = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_req) begin
                    state_nx = illegal ? S_FLT : S_RD;
                end
            end
            S_RD: begin
                o_busy    = 1'b1;
                o_memread = 1'b1;
                state_nx  = S_MRG;
            end
            S_MRG: begin
                o_busy    = 1'b1;
                o_memread = 1'b1;
                state_nx  = S_CMT;
            end
            S_CMT: begin
                o_busy   = 1'b1;
                o_done   = 1'b1;
                state_nx = S_IDLE;
            end
            S_FLT: begin
                o_busy   = 1'b1;
                o_done   = 1'b1;
                o_fault  = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Commit value, built from the live bus at the end of RD so that it sits
    // in wdata_q for the whole MRG cycle before the strobe edge.
    always_comb begin
        merged = b_membus;
        if (we_q) begin
            case (funct3_q[1:0])
                2'b00: begin
                    case (boff_q)
                        2'd0:    merged[7:0]   = wdin_q[7:0];
                        2'd1:    merged[15:8]  = wdin_q[7:0];
                        2'd2:    merged[23:16] = wdin_q[7:0];
                        default: merged[31:24] = wdin_q[7:0];
                    endcase
                end
                2'b01: begin
                    if (boff_q[1]) merged[31:16] = wdin_q[15:0];
                    else           merged[15:0]  = wdin_q[15:0];
                end
                default: merged = wdin_q;
            endcase
        end
    end

    always_comb begin
        case (boff_q)
            2'd0:    sel_b = word_q[7:0];
            2'd1:    sel_b = word_q[15:8];
            2'd2:    sel_b = word_q[23:16];
            default: sel_b = word_q[31:24];
        endcase
        sel_h = boff_q[1] ? word_q[31:16] : word_q[15:0];
        case (funct3_q)
            3'b000:  extracted = {{24{sel_b[7]}}, sel_b};
            3'b001:  extracted = {{16{sel_h[15]}}, sel_h};
            3'b100:  extracted = {24'h0, sel_b};
            3'b101:  extracted = {16'h0, sel_h};
            default: extracted = word_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nreset) begin
            state     <= S_IDLE;
            o_memaddr <= 32'h0;
            o_rdata   <= 32'h0;
            we_q      <= 1'b0;
            funct3_q  <= 3'b000;
            boff_q    <= 2'b00;
            wdin_q    <= 32'h0;
            word_q    <= 32'h0;
            // Resetting while the memory drives the bus forces a strobe edge;
            // capturing the bus makes that strobe rewrite the untouched word.
            if (state == S_RD || state == S_MRG) wdata_q <= b_membus;
            else                                 wdata_q <= 32'h0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (i_req && !illegal) begin
                        we_q      <= i_we;
                        funct3_q  <= i_funct3;
                        boff_q    <= i_addr[1:0];
                        wdin_q    <= i_wdata;
                        o_memaddr <= {i_addr[31:2], 2'b00};
                    end
                end
                S_RD: begin
                    word_q  <= b_membus;
                    wdata_q <= merged;
                end
                S_MRG: begin
                    o_rdata <= extracted;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    logic        clk = 1'b0;
    logic        i_nreset;
    logic        i_req;
    logic        i_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_busy;
    logic        o_done;
    logic        o_fault;
    logic [31:0] o_rdata;
    logic [31:0] o_memaddr;
    logic        o_memread;
    wire  [31:0] b_membus;

    always #5 clk = ~clk;

    lsu dut (
        .i_clk     (clk),
        .i_nreset  (i_nreset),
        .i_req     (i_req),
        .i_we      (i_we),
        .i_funct3  (i_funct3),
        .i_addr    (i_addr),
        .i_wdata   (i_wdata),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_fault   (o_fault),
        .o_rdata   (o_rdata),
        .o_memaddr (o_memaddr),
        .o_memread (o_memread),
        .b_membus  (b_membus)
    );

    // Memory environment: 64 words, drives the bus while o_memread is high,
    // latches the address while reading and writes on the falling edge.
    logic [31:0] mem [64];
    logic [31:0] exp_mem [64];
    logic        prev_mr = 1'b0;
    logic [5:0]  lat_idx = 6'd0;
    int          strobes = 0;
    logic        mem_init_done = 1'b0;
    logic        poke_req = 1'b0;
    logic [5:0]  poke_idx = 6'd0;
    logic [31:0] poke_val = 32'h0;

    assign b_membus = o_memread ? mem[o_memaddr[7:2]] : 32'bz;

    function automatic logic [31:0] seed_word(input int i);
        return 32'(i + 1) * 32'h9E3779B9;
    endfunction

    always @(negedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 64; i++) mem[i] = seed_word(i);
            mem_init_done = 1'b1;
        end
        if (poke_req) mem[poke_idx] = poke_val;
        if (o_memread) begin
            lat_idx = o_memaddr[7:2];
        end else if (prev_mr) begin
            mem[lat_idx] = b_membus;
            strobes++;
        end
        prev_mr = o_memread;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle expectations, one entry consumed per falling clock edge.
    typedef struct packed {
        logic        busy;
        logic        done;
        logic        fault;
        logic        mr;
        logic        chk_rd;
        logic [31:0] rdata;
        logic        chk_addr;
        logic [31:0] addr;
    } exp_t;

    exp_t expq[$];

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("busy", 32'(o_busy), 32'(e.busy));
            check("done", 32'(o_done), 32'(e.done));
            check("fault", 32'(o_fault), 32'(e.fault));
            check("memread", 32'(o_memread), 32'(e.mr));
            if (e.chk_rd)   check("rdata", o_rdata, e.rdata);
            if (e.chk_addr) check("memaddr", o_memaddr, e.addr);
        end
    end

    // Reference model, stated directly from the access rules.
    logic [31:0] exp_rdata;

    function automatic bit model_fault(input bit we, input bit [2:0] f3, input bit [31:0] a);
        case (f3)
            3'd0:    return 1'b0;
            3'd1:    return (a % 2) != 0;
            3'd2:    return (a % 4) != 0;
            3'd4:    return we;
            3'd5:    return we || ((a % 2) != 0);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input bit [31:0] word, input bit [2:0] f3,
                                               input bit [31:0] a);
        int unsigned bsh = (a % 4) * 8;
        int unsigned hsh = ((a % 4) / 2) * 16;
        bit [31:0] b = (word >> bsh) & 32'hFF;
        bit [31:0] h = (word >> hsh) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input bit [31:0] word, input bit [2:0] f3,
                                                input bit [31:0] a, input bit [31:0] wd);
        int unsigned bsh = (a % 4) * 8;
        int unsigned hsh = ((a % 4) / 2) * 16;
        bit [31:0] m;
        case (f3)
            3'd0: begin
                m = 32'hFF << bsh;
                return (word & ~m) | ((wd & 32'hFF) << bsh);
            end
            3'd1: begin
                m = 32'hFFFF << hsh;
                return (word & ~m) | ((wd & 32'hFFFF) << hsh);
            end
            default: return wd;
        endcase
    endfunction

    task automatic poke(input int idx, input logic [31:0] v);
        poke_idx = 6'(idx);
        poke_val = v;
        poke_req = 1'b1;
        @(negedge clk);
        #1;
        poke_req = 1'b0;
        exp_mem[idx] = v;
    endtask

    // One request from IDLE to the idle cycle after completion; optionally
    // keeps i_req high through the whole busy period.
    task automatic access(input bit we, input bit [2:0] f3, input bit [31:0] a,
                          input bit [31:0] wd, input bit hold, output logic [31:0] rd_seen);
        bit          flt  = model_fault(we, f3, a);
        int          idx  = int'(a[7:2]);
        bit [31:0]   wadr = {a[31:2], 2'b00};
        int          s0   = strobes;
        int          lat  = flt ? 1 : 3;
        bit [31:0]   old  = exp_mem[idx];
        if (flt) begin
            expq.push_back({1'b1, 1'b1, 1'b1, 1'b0, 1'b1, exp_rdata, 1'b0, 32'h0});
        end else begin
            exp_rdata = model_load(old, f3, a);
            if (we) exp_mem[idx] = model_store(old, f3, a, wd);
            expq.push_back({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, wadr});
            expq.push_back({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, wadr});
            expq.push_back({1'b1, 1'b1, 1'b0, 1'b0, 1'b1, exp_rdata, 1'b1, wadr});
        end
        expq.push_back({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_rdata, 1'b0, 32'h0});
        i_we     = we;
        i_funct3 = f3;
        i_addr   = a;
        i_wdata  = wd;
        i_req    = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) i_req = 1'b0;
        repeat (lat) begin
            @(posedge clk);
            #1;
        end
        i_req = 1'b0;
        @(negedge clk);
        #1;
        check("strobe_count", 32'(strobes - s0), flt ? 32'd0 : 32'd1);
        check("mem_word", mem[idx], exp_mem[idx]);
        rd_seen = o_rdata;
    endtask

    logic [31:0] rd;
    int          s_before;

    initial begin
        for (int i = 0; i < 64; i++) exp_mem[i] = seed_word(i);
        exp_rdata = 32'h0;
        i_nreset  = 1'b0;
        i_req     = 1'b0;
        i_we      = 1'b0;
        i_funct3  = 3'b000;
        i_addr    = 32'h0;
        i_wdata   = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_fault", 32'(o_fault), 32'd0);
        check("rst_memread", 32'(o_memread), 32'd0);
        check("rst_memaddr", o_memaddr, 32'h0);
        check("rst_rdata", o_rdata, 32'h0);
        check("rst_bus", b_membus, 32'h0);
        i_nreset = 1'b1;
        @(negedge clk);
        #1;

        poke(16, 32'hDEADBEEF);
        access(1'b0, 3'd2, 32'h80000040, 32'h0, 1'b0, rd);
        check("lw_lit", rd, 32'hDEADBEEF);
        check("lw_mem_lit", mem[16], 32'hDEADBEEF);

        poke(16, 32'h80FF1234);
        access(1'b0, 3'd0, 32'h80000043, 32'h0, 1'b0, rd);
        check("lb_lit", rd, 32'hFFFFFF80);
        access(1'b0, 3'd4, 32'h80000043, 32'h0, 1'b0, rd);
        check("lbu_lit", rd, 32'h00000080);

        poke(16, 32'h11223344);
        access(1'b1, 3'd0, 32'h80000041, 32'h000000AA, 1'b0, rd);
        check("sb_mem_lit", mem[16], 32'h1122AA44);

        poke(16, 32'h11223344);
        access(1'b1, 3'd1, 32'h80000042, 32'h0000BEEF, 1'b0, rd);
        check("sh_mem_lit", mem[16], 32'hBEEF3344);
        access(1'b0, 3'd1, 32'h80000042, 32'h0, 1'b0, rd);
        check("lh_lit", rd, 32'hFFFFBEEF);

        access(1'b0, 3'd2, 32'h80000042, 32'h0, 1'b1, rd);
        check("lw_mis_rdata_kept", rd, 32'hFFFFBEEF);
        access(1'b1, 3'd1, 32'h80000001, 32'h1234, 1'b1, rd);
        access(1'b0, 3'd3, 32'h80000010, 32'h0, 1'b0, rd);
        access(1'b1, 3'd4, 32'h80000010, 32'h0, 1'b0, rd);
        access(1'b1, 3'd2, 32'h80000020, 32'hA5A55A5A, 1'b1, rd);
        check("sw_hold_mem_lit", mem[8], 32'hA5A55A5A);

        // Reset during MRG of a store: the word must survive.
        poke(16, 32'hCAFEF00D);
        s_before = strobes;
        expq.push_back({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80000040});
        expq.push_back({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80000040});
        i_we     = 1'b1;
        i_funct3 = 3'd2;
        i_addr   = 32'h80000040;
        i_wdata  = 32'h12345678;
        i_req    = 1'b1;
        @(posedge clk);
        #1;
        i_req = 1'b0;
        @(posedge clk);
        #1;
        i_nreset = 1'b0;
        @(posedge clk);
        #1;
        exp_rdata = 32'h0;
        check("mrst_done", 32'(o_done), 32'd0);
        check("mrst_busy", 32'(o_busy), 32'd0);
        check("mrst_fault", 32'(o_fault), 32'd0);
        check("mrst_memread", 32'(o_memread), 32'd0);
        check("mrst_memaddr", o_memaddr, 32'h0);
        check("mrst_rdata", o_rdata, 32'h0);
        check("mrst_bus_rewrite", b_membus, 32'hCAFEF00D);
        @(negedge clk);
        #1;
        check("mrst_mem", mem[16], 32'hCAFEF00D);
        check("mrst_strobes", 32'(strobes - s_before), 32'd1);
        @(posedge clk);
        #1;
        check("mrst_bus_cleared", b_membus, 32'h0);
        check("mrst_done2", 32'(o_done), 32'd0);
        i_nreset = 1'b1;
        @(negedge clk);
        #1;

        for (int n = 0; n < 200; n++) begin
            bit        we   = 1'($urandom_range(0, 1));
            bit [2:0]  f3   = 3'($urandom_range(0, 7));
            bit [31:0] a    = 32'h80000000 | 32'($urandom_range(0, 255));
            bit [31:0] wd   = $urandom;
            bit        hold = 1'($urandom_range(0, 1));
            access(we, f3, a, wd, hold, rd);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            #1;
        end

        for (int i = 0; i < 64; i++) check("final_mem", mem[i], exp_mem[i]);
        check("queue_drained", 32'(expq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
